slv_req_apb_bridge: RTL
=======================

// Module: slv_req_apb_bridge
// PURPOSE
//  Consumes the simple req/resp stream produced by the AXI slave front-end (one beat per request) and
//  replays it as APB3/APB4 transfers toward 32-bit peripherals. A 64-bit request becomes one or two APB
//  words. APB stall timeout returns an error. Sits between the AXI slave adapter and the peripheral APB fabric.
// PARAMETERS
//  ABITS      48   request/APB address width
//  TIMEOUT    256  max ACCESS-phase cycles waiting for pready; 0 disables timeout
// PORTS
//  i_clk          in   1      clock, all logic on rising edge
//  i_rst          in   1      synchronous reset, active-high
//  i_req_valid    in   1      request present
//  o_req_ready    out  1      bridge idle, request accepted when valid&ready
//  i_req_addr     in   ABITS  byte address
//  i_req_size     in   8      transfer size in bytes (1,2,4,8 legal)
//  i_req_write    in   1      1=write, 0=read
//  i_req_wdata    in   64     write data, byte lanes by addr[2:0]
//  i_req_wstrb    in   8      write byte strobes
//  i_req_last     in   1      last beat of burst (informational, not used for sequencing)
//  o_resp_valid   out  1      one-cycle response pulse; consumer is always ready
//  o_resp_rdata   out  64     read data
//  o_resp_err     out  1      slverr / timeout / illegal request
//  o_psel         out  1      APB select
//  o_penable      out  1      APB enable
//  o_paddr        out  ABITS  APB address, 4-byte aligned
//  o_pwrite       out  1      APB direction
//  o_pwdata       out  32     APB write data
//  o_pstrb        out  4      APB strobes (0 on reads)
//  i_prdata       in   32     APB read data
//  i_pready       in   1      APB ready
//  i_pslverr      in   1      APB error
// BEHAVIOUR
//  Reset: all outputs 0 except o_req_ready=0 in reset cycle, 1 first cycle after; state IDLE, timer 0.
//  FSM: IDLE -> SETUP -> ACCESS -> (SETUP for 2nd word | RESP) -> IDLE; illegal request IDLE -> RESP.
//  IDLE: o_req_ready=1 (registered). On valid&ready latch addr/size/write/wdata/wstrb, ready->0.
//  Legality: size in {1,2,4} and addr[1:0]+size<=4 -> 1 word (word=addr[2]); size==8 and addr[2:0]==0 -> 2 words
//   (lo then hi); anything else -> RESP with err=1, no APB activity, rdata=0.
//  SETUP: psel=1, penable=0, paddr={addr[ABITS-1:3],word,2'b00}, pwrite latched, pwdata=wdata[32*word+:32],
//   pstrb=write?wstrb[4*word+:4]:0. Lasts exactly 1 cycle.
//  ACCESS: psel=1, penable=1, all APB outputs stable. On pready: capture prdata into rdata half [word];
//   err|=pslverr; drop psel/penable next cycle; go SETUP (word 1 pending) or RESP.
//   Single-word read: captured word written to BOTH halves of o_resp_rdata.
//  Timeout: timer counts ACCESS cycles with pready=0; reaching TIMEOUT ends access, err=1, skip remaining
//   word, go RESP. Timer cleared on each SETUP. TIMEOUT=0: wait forever.
//  pslverr on word 0 of a 2-word access still performs word 1; err is sticky OR.
//  RESP: o_resp_valid=1 for exactly one cycle with rdata/err; next cycle IDLE, o_req_ready=1, err/rdata cleared.
//  Latency (accept edge = N): single word, pready at once -> resp_valid in cycle N+3; two words -> N+5;
//   illegal -> N+1. Back-to-back throughput: one request per 4 cycles (single word).
//  o_psel never deasserts in ACCESS without pready or timeout; no request accepted while busy.
//  i_req_valid dropped after accept has no effect. i_rst mid-transfer: psel/penable/resp_valid 0 at next
//   edge; request dropped, no response issued.
// TESTING
//  1 Read size=4 addr=0x1004, prdata=0xCAFEBABE, pready at once -> paddr=0x1004, resp at N+3, rdata=0xCAFEBABE_CAFEBABE, err=0.
//  2 Write size=8 addr=0x2000 wdata=0x11223344_55667788 wstrb=0xF0 -> APB#1 0x2000 pwdata=0x55667788 pstrb=0;
//    APB#2 0x2004 pwdata=0x11223344 pstrb=0xF; resp at N+5.
//  3 Read size=8, pready delayed 3 cycles per word, pslverr on word 0 only -> both words run, penable held, err=1.
//  4 TIMEOUT=4, pready stuck 0 -> penable high 4 cycles, then psel=0, resp err=1, word 1 of size-8 skipped.
//  5 size=8 addr=0x3004, and size=2 addr=0x3003 -> err=1 at N+1, psel never asserted.
//  6 i_rst=1 during ACCESS -> psel=penable=0 next edge, no resp_valid, o_req_ready=1 one cycle after release.

Source files
------------

// File: rtl/slv_req_apb_bridge_if.sv
// Bundle of the request/response stream from the AXI slave front-end and the APB master bus.
// The "master" modport is the bridge; the "slave" modport is the surrounding environment.
interface slv_req_apb_bridge_if #(
  parameter int ABITS = 48
);
  logic             req_valid;
  logic             req_ready;
  logic [ABITS-1:0] req_addr;
  logic [7:0]       req_size;
  logic             req_write;
  logic [63:0]      req_wdata;
  logic [7:0]       req_wstrb;
  logic             req_last;

  logic             resp_valid;
  logic [63:0]      resp_rdata;
  logic             resp_err;

  logic             psel;
  logic             penable;
  logic [ABITS-1:0] paddr;
  logic             pwrite;
  logic [31:0]      pwdata;
  logic [3:0]       pstrb;
  logic [31:0]      prdata;
  logic             pready;
  logic             pslverr;

  modport master (
    input  req_valid, req_addr, req_size, req_write, req_wdata, req_wstrb, req_last,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output psel, penable, paddr, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_addr, req_size, req_write, req_wdata, req_wstrb, req_last,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  psel, penable, paddr, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/slv_req_apb_bridge.sv
// Replays one req/resp beat as one or two 32-bit APB transfers, with an ACCESS-phase stall timeout.
// req_last is carried by the interface but plays no part in sequencing.
module slv_req_apb_bridge #(
  parameter int ABITS   = 48,
  parameter int TIMEOUT = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  slv_req_apb_bridge_if.master bus
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic [ABITS-4:0] addr_q;
  logic             write_q;
  logic [63:0]      wdata_q;
  logic [7:0]       wstrb_q;
  logic [63:0]      rdata_q;
  logic             two_q;
  logic             word_q;
  logic             err_q;
  logic [TW-1:0]    timer_q;

  logic accept, one_word, two_word, timeout_hit, last_word, active, in_resp;

  function automatic logic fits_one_word(input logic [1:0] lo, input logic [7:0] size);
    logic [8:0] span;
    span = {7'b0, lo} + {1'b0, size};
    return ((size == 8'd1) || (size == 8'd2) || (size == 8'd4)) && (span <= 9'd4);
  endfunction

  assign accept      = bus.req_valid & ready_q;
  assign one_word    = fits_one_word(bus.req_addr[1:0], bus.req_size);
  assign two_word    = (bus.req_size == 8'd8) && (bus.req_addr[2:0] == 3'b000);
  assign timeout_hit = (TIMEOUT != 0) && !bus.pready && (timer_q == TW'(TIMEOUT - 1));
  assign last_word   = !two_q || word_q;

  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = (one_word || two_word) ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (bus.pready)       state_d = last_word ? RESP : SETUP;
        else if (timeout_hit) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // ready is registered, so it follows the state we are about to enter
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      two_q   <= 1'b0;
      word_q  <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          two_q  <= two_word;
          word_q <= two_word ? 1'b0 : bus.req_addr[2];
          err_q  <= !(one_word || two_word);
        end
        SETUP: timer_q <= '0;
        ACCESS: begin
          if (bus.pready) begin
            err_q <= err_q | bus.pslverr;
            if (!last_word) word_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Payload registers carry no reset; every output that exposes them is gated by state.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_q  <= bus.req_addr[ABITS-1:3];
      write_q <= bus.req_write;
      wdata_q <= bus.req_wdata;
      wstrb_q <= bus.req_wstrb;
      rdata_q <= '0;
    end else if (state_q == ACCESS && bus.pready) begin
      if (!two_q && !write_q) rdata_q <= {bus.prdata, bus.prdata};
      else if (word_q)        rdata_q[63:32] <= bus.prdata;
      else                    rdata_q[31:0]  <= bus.prdata;
    end
  end

  assign active  = (state_q == SETUP) || (state_q == ACCESS);
  assign in_resp = (state_q == RESP);

  assign bus.req_ready  = ready_q;
  assign bus.psel       = active;
  assign bus.penable    = (state_q == ACCESS);
  assign bus.paddr      = active ? {addr_q, word_q, 2'b00} : '0;
  assign bus.pwrite     = active & write_q;
  assign bus.pwdata     = !active ? 32'h0 : (word_q ? wdata_q[63:32] : wdata_q[31:0]);
  assign bus.pstrb      = !(active && write_q) ? 4'h0 : (word_q ? wstrb_q[7:4] : wstrb_q[3:0]);
  assign bus.resp_valid = in_resp;
  assign bus.resp_rdata = in_resp ? rdata_q : 64'h0;
  assign bus.resp_err   = in_resp & err_q;
endmodule
